// File: rtl/spi_line_capture_pkg.sv
// spi_line_capture_pkg
//   Shared definitions for the SPI line capture block: FSM state encoding,
//   bit positions inside the {CPOL,CPHA} mode field and a constant-foldable
//   ceiling-log2 helper used to size the buffer pointers.
`timescale 1ns/1ps

package spi_line_capture_pkg;

    // Line capture FSM states
    typedef enum logic [1:0] {
        ST_RECV  = 2'd0,
        ST_CLOSE = 2'd1,
        ST_DRAIN = 2'd2
    } cap_state_t;

    // Bit positions inside spi_mode = {CPOL, CPHA}
    localparam int MODE_CPHA = 0;
    localparam int MODE_CPOL = 1;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_line_capture_sync_edge.sv
// spi_sync_edge
//   Brings one asynchronous input into the fclk domain through a chain of
//   STAGES flops and derives single-cycle rise/fall pulses from the
//   synchronized level.
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   din    in   asynchronous input
//   level  out  synchronized level
//   rise   out  1-cycle pulse on a synchronized 0->1 transition
//   fall   out  1-cycle pulse on a synchronized 1->0 transition
`timescale 1ns/1ps

module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus one extra flop holding the previous synchronized
    // level; the reset value matches the idle level of the wire so reset
    // release does not fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_line_capture.sv
// spi_line_capture
//   SPI-slave line capture on the SD-card SPI pins. sdclk/sdcs_n/sddo are
//   oversampled by fclk, bytes are assembled in any of the four SPI modes and
//   stored until the terminator byte (or a full buffer) closes the line. The
//   closed line is then offered as a valid/ready byte stream.
// Ports
//   fclk        in   system clock, at least 4x sdclk
//   rst         in   asynchronous active-high reset
//   sdclk       in   SPI clock (asynchronous)
//   sdcs_n      in   SPI chip select, active low
//   sddo        in   SPI data master->slave
//   sddi        out  SPI data slave->master, tied high
//   spi_mode    in   {CPOL,CPHA}, taken only while chip select is high
//   rd_data     out  current line byte
//   rd_valid    out  rd_data valid
//   rd_ready    in   consumer accepts rd_data
//   line_len    out  length of the line being drained
//   line_trunc  out  line was closed by a full buffer instead of TERM
//   line_done   out  1-cycle pulse when a line closes (also for length 0)
//   ovf_flag    out  sticky, a byte was dropped while a line was pending
//   ovf_clr     in   clears ovf_flag (a simultaneous drop keeps it set)
// Configuration
//   SPI_PRINT_EN  simulation only: prints each closed line and each dropped
//                 byte. Hardware behaviour is identical either way.
`timescale 1ns/1ps

module spi_line_capture
    import spi_line_capture_pkg::*;
#(
    parameter int         DEPTH       = 256,
    parameter logic [7:0] TERM        = 8'd10,
    parameter int         SYNC_STAGES = 2,
    parameter bit         LSB_FIRST   = 1'b0,
    localparam int        AW          = clog2(DEPTH)
) (
    input  logic          fclk,
    input  logic          rst,
    input  logic          sdclk,
    input  logic          sdcs_n,
    input  logic          sddo,
    output logic          sddi,
    input  logic [1:0]    spi_mode,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW:0]   line_len,
    output logic          line_trunc,
    output logic          line_done,
    output logic          ovf_flag,
    input  logic          ovf_clr
);

    localparam logic [AW:0] ONE       = (AW+1)'(1);
    localparam logic [AW:0] LAST_SLOT = (AW+1)'(DEPTH - 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level, cs_rise_unused, cs_fall_unused;
    logic sddo_level, sddo_rise_unused, sddo_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(fclk), .rst(rst), .din(sdclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(fclk), .rst(rst), .din(sdcs_n),
        .level(cs_level), .rise(cs_rise_unused), .fall(cs_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sddo (
        .clk(fclk), .rst(rst), .din(sddo),
        .level(sddo_level), .rise(sddo_rise_unused), .fall(sddo_fall_unused)
    );

    logic [1:0] mode_q;
    logic       armed_q;
    logic [7:0] shift_q;
    logic [2:0] bitcnt_q;
    logic       byte_valid_q;
    logic [7:0] byte_q;

    logic       sample_on_rise;
    logic       sample_edge;
    logic       shift_edge;
    logic       sample_en;
    logic [7:0] shift_next;

    // CPOL==CPHA samples on the rising edge, otherwise on the falling one.
    // The opposite edge is where the master shifts data out.
    always_comb begin
        sample_on_rise = (mode_q[MODE_CPOL] == mode_q[MODE_CPHA]);
        sample_edge    = sample_on_rise ? sclk_rise : sclk_fall;
        shift_edge     = sample_on_rise ? sclk_fall : sclk_rise;
        sample_en      = ~cs_level & armed_q & sample_edge;
        shift_next     = LSB_FIRST ? {sddo_level, shift_q[7:1]}
                                   : {shift_q[6:0], sddo_level};
    end

    // Mode is only taken while chip select is idle, so a frame always runs in
    // one mode. In CPHA=1 the shifter stays disarmed until the leading (shift)
    // edge has gone by, so a stray sample-polarity edge at CS fall is ignored.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            mode_q  <= 2'b00;
            armed_q <= 1'b0;
        end else if (cs_level) begin
            mode_q  <= spi_mode;
            armed_q <= ~spi_mode[MODE_CPHA];
        end else if (shift_edge) begin
            armed_q <= 1'b1;
        end
    end

    // Bit assembly. Deasserting chip select throws away a partial byte; the
    // eighth sample produces a one-cycle byte_valid with the finished byte.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            shift_q      <= 8'h00;
            bitcnt_q     <= 3'd0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
        end else begin
            byte_valid_q <= 1'b0;
            if (cs_level) begin
                shift_q  <= 8'h00;
                bitcnt_q <= 3'd0;
            end else if (sample_en) begin
                shift_q <= shift_next;
                if (bitcnt_q == 3'd7) begin
                    bitcnt_q     <= 3'd0;
                    byte_valid_q <= 1'b1;
                    byte_q       <= shift_next;
                end else begin
                    bitcnt_q <= bitcnt_q + 3'd1;
                end
            end
        end
    end

    cap_state_t  state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] len_q, len_d;
    logic        trunc_q, trunc_d;
    logic        data_ok_q, data_ok_d;
    logic        ovf_q;
    logic        mem_we;
    logic        drop;
    logic [7:0]  mem [DEPTH];
    logic [7:0]  mem_q;

    // data_ok_q says the registered RAM output belongs to rd_ptr_q; it drops
    // for one cycle whenever the read pointer moves.
    assign rd_valid   = (state_q == ST_DRAIN) && data_ok_q;
    assign rd_data    = mem_q;
    assign line_done  = (state_q == ST_CLOSE);
    assign line_len   = len_q;
    assign line_trunc = trunc_q;
    assign ovf_flag   = ovf_q;
    assign sddi       = 1'b1;

    // Next-state logic. Length and truncation are settled on the way into
    // CLOSE so they are already valid while line_done pulses. A byte landing
    // in the last slot is kept and then closes the line as truncated.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        len_d     = len_q;
        trunc_d   = trunc_q;
        data_ok_d = data_ok_q;
        mem_we    = 1'b0;
        drop      = 1'b0;
        case (state_q)
            ST_RECV: begin
                if (byte_valid_q) begin
                    if (byte_q == TERM) begin
                        state_d = ST_CLOSE;
                        len_d   = wr_ptr_q;
                        trunc_d = 1'b0;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE;
                        if (wr_ptr_q == LAST_SLOT) begin
                            state_d = ST_CLOSE;
                            len_d   = wr_ptr_q + ONE;
                            trunc_d = 1'b1;
                        end
                    end
                end
            end
            ST_CLOSE: begin
                drop      = byte_valid_q;
                rd_ptr_d  = '0;
                data_ok_d = 1'b0;
                state_d   = (len_q == '0) ? ST_RECV : ST_DRAIN;
            end
            ST_DRAIN: begin
                drop      = byte_valid_q;
                data_ok_d = 1'b1;
                if (rd_valid && rd_ready) begin
                    data_ok_d = 1'b0;
                    rd_ptr_d  = rd_ptr_q + ONE;
                    if (rd_ptr_q + ONE == len_q) begin
                        state_d  = ST_RECV;
                        wr_ptr_d = '0;
                        trunc_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_RECV;
        endcase
    end

    // FSM and pointer registers. The overflow flag is sticky and a drop in
    // the same cycle as ovf_clr keeps it set.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RECV;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            trunc_q   <= 1'b0;
            data_ok_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            len_q     <= len_d;
            trunc_q   <= trunc_d;
            data_ok_q <= data_ok_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Line buffer write port; no reset so it maps onto block RAM.
    always_ff @(posedge fclk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= byte_q;
        end
    end

    // Registered read port. Writes and reads never overlap in time because
    // writes only happen in RECV and the output is only used in DRAIN.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            mem_q <= 8'h00;
        end else begin
            mem_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

`ifdef SPI_PRINT_EN
    // Simulation-only printout of each closed line and each dropped byte.
    always @(posedge fclk) begin
        if (!rst && state_q == ST_CLOSE) begin
            $write("spi line: <");
            for (int i = 0; i < DEPTH; i++) begin
                if (i < int'(len_q)) begin
                    $write("%s", mem[i]);
                end
            end
            $write(">");
            if (trunc_q) begin
                $write(" [trunc]");
            end
            $write("\n");
        end
        if (!rst && drop) begin
            $display("spi line: overflow, dropped byte 8'h%02h", byte_q);
        end
    end
`endif

endmodule

// File: tb/tb_spi_line_capture.sv
// tb_spi_line_capture
//   Directed bench for spi_line_capture (DEPTH=4, TERM=8'd10, MSB first).
//   A bit-banged SPI master drives frames in all four modes; a negedge
//   monitor records line_done pulses and rd_valid cycles; every check goes
//   through checkOutput with hand-computed expectations.
`timescale 1ns/1ps

module tb_spi_line_capture;

    localparam int         DEPTH = 4;
    localparam int         AW    = 2;
    localparam logic [7:0] TERM  = 8'd10;
    localparam int         HALF  = 40;

    logic          fclk = 1'b0;
    logic          rst;
    logic          sdclk;
    logic          sdcs_n;
    logic          sddo;
    logic          sddi;
    logic [1:0]    spi_mode;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW:0]   line_len;
    logic          line_trunc;
    logic          line_done;
    logic          ovf_flag;
    logic          ovf_clr;

    int tests_run    = 0;
    int tests_failed = 0;

    int          done_count   = 0;
    int          valid_cycles = 0;
    logic [AW:0] done_len     = '0;
    logic        done_trunc   = 1'b0;

    logic [7:0] got [0:15];
    int         got_n;
    int         hold_viol;

    always #5 fclk = ~fclk;

    spi_line_capture #(
        .DEPTH(DEPTH), .TERM(TERM), .SYNC_STAGES(2), .LSB_FIRST(1'b0)
    ) dut (
        .fclk(fclk), .rst(rst), .sdclk(sdclk), .sdcs_n(sdcs_n), .sddo(sddo),
        .sddi(sddi), .spi_mode(spi_mode), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .line_len(line_len),
        .line_trunc(line_trunc), .line_done(line_done), .ovf_flag(ovf_flag),
        .ovf_clr(ovf_clr)
    );

    // Monitor: records every line_done pulse with its length/trunc and counts
    // rd_valid cycles, sampled on the falling edge.
    always @(negedge fclk) begin
        if (line_done) begin
            done_count <= done_count + 1;
            done_len   <= line_len;
            done_trunc <= line_trunc;
        end
        if (rd_valid) begin
            valid_cycles <= valid_cycles + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic beginFrame(input logic [1:0] mode);
        sdcs_n   = 1'b1;
        spi_mode = mode;
        sdclk    = mode[1];
        sddo     = 1'b0;
        repeat (8) @(posedge fclk);
        #2;
        sdcs_n = 1'b0;
        #(HALF);
    endtask

    task automatic endFrame();
        #(HALF);
        sdcs_n = 1'b1;
        repeat (8) @(posedge fclk);
    endtask

    // Shifts out the top nbits of value, MSB first, in the current spi_mode.
    task automatic applyStimulus(input logic [7:0] value, input int nbits);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = value[7-i];
            if (!spi_mode[0]) begin
                sddo = b;
                #(HALF);
                sdclk = ~sdclk;
                #(HALF);
                sdclk = ~sdclk;
            end else begin
                sdclk = ~sdclk;
                sddo  = b;
                #(HALF);
                sdclk = ~sdclk;
                #(HALF);
            end
        end
    endtask

    task automatic sendLine(input logic [1:0] mode, input string s, input bit with_term);
        beginFrame(mode);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i], 8);
        end
        if (with_term) begin
            applyStimulus(TERM, 8);
        end
        endFrame();
    endtask

    task automatic waitDone(input int base, input string tag);
        int k;
        k = 0;
        while (done_count == base && k < 1000) begin
            @(negedge fclk);
            k++;
        end
        repeat (2) @(negedge fclk);
        checkOutput({tag, "_done"}, done_count - base, 1);
    endtask

    // Accepts n bytes with rd_ready high on every period-th cycle; also
    // counts cases where a pending byte changed or vanished before acceptance.
    task automatic drainLine(input int n, input int period);
        int   k;
        logic prev_wait;
        logic [7:0] prev_data;
        k         = 0;
        got_n     = 0;
        hold_viol = 0;
        prev_wait = 1'b0;
        prev_data = 8'h00;
        while (got_n < n && k < 400) begin
            @(negedge fclk);
            k++;
            rd_ready = ((k % period) == 0);
            if (prev_wait && (!rd_valid || rd_data !== prev_data)) begin
                hold_viol++;
            end
            if (rd_valid && rd_ready) begin
                got[got_n] = rd_data;
                got_n++;
                prev_wait = 1'b0;
            end else begin
                prev_wait = rd_valid;
                prev_data = rd_data;
            end
        end
        @(negedge fclk);
        rd_ready = 1'b0;
        repeat (3) @(negedge fclk);
    endtask

    initial begin
        int base;
        int vbase;
        int k;

        rst      = 1'b1;
        sdclk    = 1'b0;
        sdcs_n   = 1'b1;
        sddo     = 1'b0;
        spi_mode = 2'b00;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;

        // Reset state
        repeat (3) @(negedge fclk);
        checkOutput("rst_valid", rd_valid, 0);
        checkOutput("rst_data", rd_data, 0);
        checkOutput("rst_len", line_len, 0);
        checkOutput("rst_trunc", line_trunc, 0);
        checkOutput("rst_done", line_done, 0);
        checkOutput("rst_ovf", ovf_flag, 0);
        checkOutput("rst_sddi", sddi, 1);
        rst = 1'b0;
        repeat (4) @(negedge fclk);

        // Mode 0, "HI\n"
        base = done_count;
        sendLine(2'b00, "HI", 1'b1);
        waitDone(base, "hi");
        checkOutput("hi_len", done_len, 2);
        checkOutput("hi_trunc", done_trunc, 0);
        drainLine(2, 1);
        checkOutput("hi_count", got_n, 2);
        checkOutput("hi_b0", got[0], 8'h48);
        checkOutput("hi_b1", got[1], 8'h49);
        checkOutput("hi_ovf", ovf_flag, 0);
        checkOutput("hi_idle", rd_valid, 0);

        // Modes 1..3, 8'hA5 + TERM
        for (int m = 1; m < 4; m++) begin
            base = done_count;
            beginFrame(2'(m));
            applyStimulus(8'hA5, 8);
            applyStimulus(TERM, 8);
            endFrame();
            waitDone(base, $sformatf("mode%0d", m));
            checkOutput($sformatf("mode%0d_len", m), done_len, 1);
            drainLine(1, 1);
            checkOutput($sformatf("mode%0d_data", m), got[0], 8'hA5);
        end

        // Chip select raised after 5 bits, then a clean "A\n"
        beginFrame(2'b00);
        applyStimulus(8'hFF, 5);
        endFrame();
        base = done_count;
        sendLine(2'b00, "A", 1'b1);
        waitDone(base, "partial");
        checkOutput("partial_len", done_len, 1);
        drainLine(1, 1);
        checkOutput("partial_data", got[0], 8'h41);

        // Full buffer: "ABCDE\n" with the consumer stalled
        base = done_count;
        sendLine(2'b00, "ABCDE", 1'b1);
        waitDone(base, "full");
        checkOutput("full_len", done_len, 4);
        checkOutput("full_trunc", done_trunc, 1);
        checkOutput("full_ovf", ovf_flag, 1);
        checkOutput("full_pending", rd_valid, 1);
        drainLine(4, 1);
        checkOutput("full_count", got_n, 4);
        checkOutput("full_b0", got[0], 8'h41);
        checkOutput("full_b1", got[1], 8'h42);
        checkOutput("full_b2", got[2], 8'h43);
        checkOutput("full_b3", got[3], 8'h44);
        checkOutput("full_trunc_cleared", line_trunc, 0);
        checkOutput("full_no_extra_line", done_count - base, 1);
        @(negedge fclk);
        ovf_clr = 1'b1;
        @(negedge fclk);
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", ovf_flag, 0);

        // Empty line: TERM only
        base  = done_count;
        vbase = valid_cycles;
        sendLine(2'b00, "", 1'b1);
        waitDone(base, "empty");
        checkOutput("empty_len", done_len, 0);
        repeat (20) @(negedge fclk);
        checkOutput("empty_no_valid", valid_cycles - vbase, 0);

        // Back-pressured drain, ready one cycle in three
        base = done_count;
        sendLine(2'b00, "XYZ", 1'b1);
        waitDone(base, "xyz");
        drainLine(3, 3);
        checkOutput("xyz_count", got_n, 3);
        checkOutput("xyz_b0", got[0], 8'h58);
        checkOutput("xyz_b1", got[1], 8'h59);
        checkOutput("xyz_b2", got[2], 8'h5A);
        checkOutput("xyz_hold", hold_viol, 0);

        // Reset in the middle of a drain
        base = done_count;
        sendLine(2'b00, "PQ", 1'b1);
        waitDone(base, "pq");
        k = 0;
        while (!rd_valid && k < 50) begin
            @(negedge fclk);
            k++;
        end
        checkOutput("pq_valid", rd_valid, 1);
        @(posedge fclk);
        #2;
        rst = 1'b1;
        @(negedge fclk);
        checkOutput("rst_mid_valid", rd_valid, 0);
        checkOutput("rst_mid_len", line_len, 0);
        rst = 1'b0;
        repeat (4) @(negedge fclk);

        // Capture still works after the mid-drain reset
        base = done_count;
        sendLine(2'b00, "Z", 1'b1);
        waitDone(base, "post");
        checkOutput("post_len", done_len, 1);
        drainLine(1, 1);
        checkOutput("post_data", got[0], 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
